// File: rtl/host_msix_monitor.sv
// MSI-X message detector on the host write stream: programmable vector table, per-vector
// pending bits and saturating hit counters, and an event FIFO of unmasked hits.
module host_msix_monitor #(
    parameter int NUM_VEC      = 8,
    parameter int ADDR_W       = 64,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 8,
    parameter int DROP_ON_FULL = 0,
    localparam int IDX_W       = $clog2(NUM_VEC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [31:0]        wr_data,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [31:0]        cfg_data,
    input  logic               cfg_mask,
    input  logic               clr_valid,
    input  logic [IDX_W-1:0]   clr_vec,
    input  logic               clr_ovf,
    output logic [NUM_VEC-1:0] pending,
    output logic               intr_any,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [IDX_W-1:0]   evt_vec,
    input  logic [IDX_W-1:0]   cnt_idx,
    output logic [CNT_W-1:0]   cnt_val,
    output logic               ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Vector table
    logic [ADDR_W-1:0]  addr_q [NUM_VEC];
    logic [31:0]        data_q [NUM_VEC];
    logic [NUM_VEC-1:0] mask_q;

    // Per-vector status
    logic [NUM_VEC-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]   cnt_q [NUM_VEC];
    logic [CNT_W-1:0]   cnt_d [NUM_VEC];
    logic               ovf_q, ovf_d;

    // Event FIFO
    logic [IDX_W-1:0]   fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;

    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic               unm_hit;
    logic               fifo_full;
    logic               accept;
    logic               push_req;
    logic               push;
    logic               pop;
    logic               drop;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_VEC - 1; i >= 0; i--) begin
            if (wr_addr == addr_q[i] && wr_data == data_q[i]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign unm_hit   = hit & ~mask_q[hit_idx];
    assign fifo_full = (occ_q == OCC_W'(FIFO_DEPTH));

    generate
        if (DROP_ON_FULL != 0) begin : g_drop
            assign wr_ready = 1'b1;
        end else begin : g_stall
            // Only a write that would need a FIFO slot is held off.
            assign wr_ready = ~(fifo_full & unm_hit);
        end
    endgenerate

    assign accept    = wr_valid & wr_ready;
    assign push_req  = accept & unm_hit;
    assign push      = push_req & ~fifo_full;
    assign drop      = push_req & fifo_full;
    assign pop       = evt_valid & evt_ready;

    assign evt_valid = (occ_q != '0);
    assign evt_vec   = fifo_q[rptr_q];
    assign pending   = pending_q;
    assign intr_any  = |(pending_q & ~mask_q);
    assign cnt_val   = cnt_q[cnt_idx];
    assign ovf       = ovf_q;

    // Clear is applied first so a same-cycle hit on the same vector wins.
    always_comb begin
        pending_d = pending_q;
        cnt_d     = cnt_q;
        if (clr_valid) begin
            pending_d[clr_vec] = 1'b0;
            cnt_d[clr_vec]     = '0;
        end
        if (accept && hit) begin
            pending_d[hit_idx] = 1'b1;
            if (unm_hit) begin
                cnt_d[hit_idx] = sat_inc(cnt_d[hit_idx]);
            end
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VEC; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            mask_q    <= '1;
            pending_q <= '0;
            ovf_q     <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            occ_q     <= '0;
        end else begin
            if (cfg_we) begin
                addr_q[cfg_idx] <= cfg_addr;
                data_q[cfg_idx] <= cfg_data;
                mask_q[cfg_idx] <= cfg_mask;
            end
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            occ_q     <= occ_d;
        end
    end

    // FIFO payload needs no reset; occupancy gates its visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q] <= hit_idx;
        end
    end

endmodule
